// File: rtl/br_seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// br_seq_pkg : state type, widths and odd-parity helper.  Rev 1.0
// ------------------------------------------------------------------
package br_seq_pkg;

  localparam int SYL_W       = 14;
  localparam int PAR_BIT     = 14;
  localparam int SENSE_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SENSE = 3'd2,
    ST_XFER  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Odd parity over the low PAR_BIT bits: a word is good when the XOR is 1.
  function automatic logic odd_par_ok(input logic [SYL_W-1:0] v);
    return ^v[PAR_BIT-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_check.sv
`default_nettype none
// ------------------------------------------------------------------
// br_check : parity check, channel compare and syllable select.  Rev 1.0
// ------------------------------------------------------------------
module br_check
  import br_seq_pkg::*;
(
  input  logic             i_duplex,
  input  logic [SYL_W-1:0] i_bra,
  input  logic [SYL_W-1:0] i_brb,
  output logic [SYL_W-1:0] o_syl,
  output logic             o_perra,
  output logic             o_perrb,
  output logic             o_disagree
);

  logic w_good_a;
  logic w_good_b;

  always_comb begin
    w_good_a   = odd_par_ok(i_bra);
    w_good_b   = odd_par_ok(i_brb);
    o_perra    = ~w_good_a;
    o_perrb    = i_duplex & ~w_good_b;
    o_disagree = i_duplex & w_good_a & w_good_b & (i_bra != i_brb);
    // B is used only to cover a bad A; with both bad, A is returned flagged.
    o_syl      = (i_duplex && !w_good_a && w_good_b) ? i_brb : i_bra;
  end

endmodule
`default_nettype wire

// File: rtl/br_cycle_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// br_cycle_sequencer : clear/strobe/set/check sequencing of buffer regs A/B.
// BR_DUPLEX_COMPARE_EN selects duplex (A+B) vs simplex (A only).  Rev 1.0
// ------------------------------------------------------------------
module br_cycle_sequencer
  import br_seq_pkg::*;
#(
  parameter int SENSE_CYC = 2
)
(
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             REQ,
  input  logic             WR,
  input  logic [1:0]       MPAIR,
  input  logic [SYL_W-1:0] BRA,
  input  logic [SYL_W-1:0] BRB,
  output logic             A1CBRVN,
  output logic             A2CBRVN,
  output logic             A1SBRXV,
  output logic             A2SBRXV,
  output logic [7:0]       MSTRB,
  output logic             BUSY,
  output logic             ACK,
  output logic [SYL_W-1:0] DOUT,
  output logic             PERRA,
  output logic             PERRB,
  output logic             DISAGREE
);

`ifdef BR_DUPLEX_COMPARE_EN
  localparam logic DUPLEX_EN = 1'b1;
`else
  localparam logic DUPLEX_EN = 1'b0;
`endif

  localparam logic [SENSE_CNT_W-1:0] CNT_LOAD = SENSE_CNT_W'(SENSE_CYC);
  localparam logic [SENSE_CNT_W-1:0] CNT_ONE  = SENSE_CNT_W'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SENSE_CNT_W-1:0] r_cnt;
  logic [SENSE_CNT_W-1:0] w_cnt_nxt;
  logic                   r_wr;
  logic [1:0]             r_pair;
  logic                   r_hold;
  logic                   w_accept;
  logic                   w_clr_n;
  logic [SYL_W-1:0]       r_dout;
  logic                   r_perra;
  logic                   r_perrb;
  logic                   r_dis;
  logic [SYL_W-1:0]       w_syl;
  logic                   w_perra;
  logic                   w_perrb;
  logic                   w_dis;

  br_check u_check (
    .i_duplex   (DUPLEX_EN),
    .i_bra      (BRA),
    .i_brb      (BRB),
    .o_syl      (w_syl),
    .o_perra    (w_perra),
    .o_perrb    (w_perrb),
    .o_disagree (w_dis)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_pair  <= 2'd0;
      r_hold  <= 1'b0;
      r_dout  <= '0;
      r_perra <= 1'b0;
      r_perrb <= 1'b0;
      r_dis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Keeps BUSY up for the idle cycle that follows ACK.
      r_hold  <= (r_state == ST_DONE);
      if (w_accept) begin
        r_wr   <= WR;
        r_pair <= MPAIR;
      end
      if (r_state == ST_CHECK) begin
        r_dout  <= w_syl;
        r_perra <= w_perra;
        r_perrb <= w_perrb;
        r_dis   <= w_dis;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_clr_n     = 1'b1;
    A1SBRXV     = 1'b0;
    A2SBRXV     = 1'b0;
    MSTRB       = 8'h00;
    ACK         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (REQ && !r_hold) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clr_n = 1'b0;
        if (r_wr) begin
          w_state_nxt = ST_XFER;
        end else begin
          w_state_nxt = ST_SENSE;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_SENSE: begin
        MSTRB[{r_pair, 1'b0}] = 1'b1;
        MSTRB[{r_pair, 1'b1}] = DUPLEX_EN;
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      ST_XFER: begin
        A1SBRXV     = 1'b1;
        A2SBRXV     = DUPLEX_EN;
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: w_state_nxt = ST_DONE;
      ST_DONE: begin
        ACK         = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign A1CBRVN  = w_clr_n;
  assign BUSY     = (r_state != ST_IDLE) || r_hold;
  assign DOUT     = r_dout;
  assign PERRA    = r_perra;
  assign PERRB    = r_perrb;
  assign DISAGREE = r_dis;

`ifdef BR_DUPLEX_COMPARE_EN
  assign A2CBRVN = w_clr_n;
`else
  // Simplex: register B is held cleared from the first cycle out of reset.
  logic r_run;
  always_ff @(posedge CLK) begin
    if (!RSTN) r_run <= 1'b0;
    else       r_run <= 1'b1;
  end
  assign A2CBRVN = ~r_run;
`endif

endmodule
`default_nettype wire

// File: tb/tb_br_cycle_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_br_cycle_sequencer : randomized directed bench with timeline model.  Rev 1.0
// ------------------------------------------------------------------
module tb_br_cycle_sequencer;

  localparam int S      = 2;
  localparam int LAT_RD = 3 + S;
  localparam int LAT_WR = 4;
  localparam int GAP_RD = 5 + S;
`ifdef BR_DUPLEX_COMPARE_EN
  localparam bit DUPLEX = 1'b1;
`else
  localparam bit DUPLEX = 1'b0;
`endif
  localparam logic [30:0] RST_VEC = {1'b1, 1'b1, 2'b00, 8'h00, 2'b00, 14'h0000, 3'b000};

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        REQ;
  logic        WR;
  logic [1:0]  MPAIR;
  logic [13:0] BRA;
  logic [13:0] BRB;
  logic        A1CBRVN, A2CBRVN, A1SBRXV, A2SBRXV;
  logic [7:0]  MSTRB;
  logic        BUSY, ACK;
  logic [13:0] DOUT;
  logic        PERRA, PERRB, DISAGREE;

  int n_tests = 0;
  int n_fail  = 0;

  br_cycle_sequencer #(.SENSE_CYC(S)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WR(WR), .MPAIR(MPAIR),
    .BRA(BRA), .BRB(BRB),
    .A1CBRVN(A1CBRVN), .A2CBRVN(A2CBRVN), .A1SBRXV(A1SBRXV), .A2SBRXV(A2SBRXV),
    .MSTRB(MSTRB), .BUSY(BUSY), .ACK(ACK), .DOUT(DOUT),
    .PERRA(PERRA), .PERRB(PERRB), .DISAGREE(DISAGREE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] obs_ctl();
    return {A1CBRVN, A2CBRVN, A1SBRXV, A2SBRXV, MSTRB, BUSY, ACK};
  endfunction

  function automatic logic [30:0] obs_all();
    return {A1CBRVN, A2CBRVN, A1SBRXV, A2SBRXV, MSTRB, BUSY, ACK, DOUT, PERRA, PERRB, DISAGREE};
  endfunction

  // Expected control outputs in cycle k after acceptance (k=1 is the clear cycle).
  function automatic logic [13:0] exp_ctl(input bit wr, input int p, input int k);
    int   lat;
    logic clr_a, clr_b, set_a, set_b, busy, ack;
    logic [7:0] strb;
    lat   = wr ? LAT_WR : LAT_RD;
    clr_a = (k != 1);
    clr_b = DUPLEX ? (k != 1) : 1'b0;
    set_a = wr && (k == 2);
    set_b = DUPLEX && wr && (k == 2);
    strb  = 8'h00;
    if (!wr && k >= 2 && k <= S + 1) begin
      strb = 8'(1 << (2 * p));
      if (DUPLEX) strb = strb | 8'(1 << (2 * p + 1));
    end
    busy = (k <= lat + 1);
    ack  = (k == lat);
    return {clr_a, clr_b, set_a, set_b, strb, busy, ack};
  endfunction

  // Expected {DOUT, PERRA, PERRB, DISAGREE}.
  function automatic logic [16:0] exp_res(input logic [13:0] a, input logic [13:0] b);
    bit ga, gb;
    ga = ^a;
    gb = ^b;
    if (!DUPLEX) return {a, ~ga, 1'b0, 1'b0};
    if (ga)      return {a, 1'b0, ~gb, gb && (a != b)};
    if (gb)      return {b, 1'b1, 1'b0, 1'b0};
    return {a, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic run_access(input bit wr, input int p, input logic [13:0] a, input logic [13:0] b);
    int lat;
    bit pulse;
    lat   = wr ? LAT_WR : LAT_RD;
    pulse = 1'($urandom_range(0, 1));
    BRA = a; BRB = b; WR = wr; MPAIR = 2'(p); REQ = 1'b1;
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge CLK);
      chk($sformatf("ctl wr=%0d p=%0d k=%0d", wr, p, k), 32'(obs_ctl()), 32'(exp_ctl(wr, p, k)));
      if (k == lat || k == lat + 1)
        chk($sformatf("result k=%0d a=%h b=%h", k, a, b),
            32'({DOUT, PERRA, PERRB, DISAGREE}), 32'(exp_res(a, b)));
      if (k == 1) begin
        REQ = 1'b0; WR = 1'($urandom); MPAIR = 2'($urandom);
      end
      if (k == 2) REQ = pulse;
      if (k == 3) REQ = 1'b0;
    end
  endtask

  initial begin
    int last;
    int nacks;
    RSTN = 1'b0; REQ = 1'b0; WR = 1'b0; MPAIR = 2'd0; BRA = '0; BRB = '0;
    repeat (2) @(negedge CLK);
    chk("reset_state", 32'(obs_all()), 32'(RST_VEC));
    RSTN = 1'b1;
    @(negedge CLK);
    chk("idle_ctl", 32'(obs_ctl()), 32'({1'b1, DUPLEX, 2'b00, 8'h00, 2'b00}));

    run_access(1'b0, 2, 14'h2001, 14'h2001);
    run_access(1'b1, 1, 14'h0001, 14'h0003);
    run_access(1'b0, 0, 14'h0000, 14'h0007);
    run_access(1'b0, 3, 14'h0001, 14'h0002);
    run_access(1'b0, 1, 14'h0000, 14'h0000);
    for (int i = 0; i < 24; i++)
      run_access(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 14'($urandom), 14'($urandom));

    // Continuous request: back-to-back reads.
    REQ = 1'b1; WR = 1'b0; MPAIR = 2'($urandom); BRA = 14'h2001; BRB = 14'h2001;
    last = 0; nacks = 0;
    for (int c = 1; c <= 4 * GAP_RD; c++) begin
      @(negedge CLK);
      if (ACK) begin
        if (nacks == 0) chk("cont_first_ack", 32'(c), 32'(LAT_RD));
        else            chk("cont_ack_gap", 32'(c - last), 32'(GAP_RD));
        last = c;
        nacks++;
      end
    end
    REQ = 1'b0;
    chk("cont_ack_count", 32'(nacks), 32'd4);
    for (int c = 0; c < 20 && BUSY; c++) @(negedge CLK);
    chk("drain_idle", 32'(BUSY), 32'd0);

    // Reset while sensing aborts the cycle.
    run_access(1'b0, 1, 14'h2001, 14'h2001);
    REQ = 1'b1; WR = 1'b0; MPAIR = 2'd1;
    @(negedge CLK);
    REQ = 1'b0;
    @(negedge CLK);
    chk("pre_abort_strobe", 32'(MSTRB), 32'(DUPLEX ? 8'h0C : 8'h04));
    RSTN = 1'b0;
    @(negedge CLK);
    chk("abort_reset_state", 32'(obs_all()), 32'(RST_VEC));
    RSTN = 1'b1;
    nacks = 0;
    repeat (12) begin
      @(negedge CLK);
      if (ACK) nacks++;
    end
    chk("abort_no_ack", 32'(nacks), 32'd0);
    run_access(1'b1, 3, 14'h1234, 14'h0F0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
